// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined Y86-64 core.
// Serves one 8-byte little-endian load or store at a time over a valid/ready
// request channel. After a programmable number of wait states it answers with
// a one-cycle response pulse. Out-of-range accesses are flagged instead of
// touching the array, and that flag drives the memory stage's stat 4'h3.

module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  // Highest legal start address; compared in 64 bits so huge addresses cannot wrap.
  localparam logic [63:0] LAST_OK  = 64'(DEPTH - 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_addr;
  logic        r_we;
  logic [63:0] r_wdata;
  logic        r_ready;
  logic        r_resp_valid;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        r_busy;
  logic [7:0]  r_mem [DEPTH];

  state_t      w_next_state;
  logic [3:0]  w_next_cnt;
  logic        w_accept;
  logic        w_enter_resp;
  logic [63:0] w_addr;
  logic        w_we;
  logic [63:0] w_wdata;
  logic        w_err;
  logic [AW-1:0] w_base;
  logic [63:0] w_load_data;
  logic        w_mem_we;

  // Next-state and wait-counter logic for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY > 0) begin
            w_next_state = ST_WAIT;
            w_next_cnt   = LAT_INIT;
          end else begin
            w_next_state = ST_RESP;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Operand selection: with zero wait states RESP is entered straight from
  // IDLE, so the live request fields are used before they are latched.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_addr  = req_addr;
      w_we    = req_we;
      w_wdata = req_wdata;
    end else begin
      w_addr  = r_addr;
      w_we    = r_we;
      w_wdata = r_wdata;
    end
    w_err        = (w_addr > LAST_OK);
    w_base       = w_addr[AW-1:0];
    w_enter_resp = (w_next_state == ST_RESP);
    w_mem_we     = rst_n && w_enter_resp && w_we && !w_err;
  end

  // Assemble the little-endian 8-byte load word starting at the access address.
  always_comb begin
    w_load_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      w_load_data[8*i +: 8] = r_mem[w_base + AW'(i)];
    end
  end

  // Byte-array write on the edge that enters RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_base + AW'(i)] <= w_wdata[8*i +: 8];
      end
    end
  end

  // State, latched request and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= 64'd0;
      r_we         <= 1'b0;
      r_wdata      <= 64'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 64'd0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_wdata <= req_wdata;
      end
      r_ready      <= (w_next_state == ST_IDLE);
      r_resp_valid <= (w_next_state == ST_RESP);
      r_busy       <= (w_next_state != ST_IDLE);
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? 64'd0 : w_load_data;
      end else begin
        r_err   <= 1'b0;
        r_rdata <= 64'd0;
      end
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states (index 0) and
// one with none (index 1), both 1024 bytes, checked against a byte-array model.

module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        v   [2];
  logic        we  [2];
  logic [63:0] a   [2];
  logic [63:0] wd  [2];
  logic        rdy [2];
  logic        rv  [2];
  logic [63:0] rd  [2];
  logic        er  [2];
  logic        bs  [2];

  int n_tests;
  int n_fail;

  logic [7:0] mm [2][DEPTH];

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic        chk_data;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t tbl [12];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v[0]), .req_we(we[0]), .req_addr(a[0]), .req_wdata(wd[0]),
    .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]),
    .resp_err(er[0]), .busy(bs[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v[1]), .req_we(we[1]), .req_addr(a[1]), .req_wdata(wd[1]),
    .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]),
    .resp_err(er[1]), .busy(bs[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: an access is legal when all 8 bytes fit below DEPTH.
  function automatic void model(input int s, input logic w, input logic [63:0] ad,
                                input logic [63:0] dat,
                                output logic [63:0] r, output logic e);
    e = (ad + 64'd8 > 64'(DEPTH)) || (ad > 64'(DEPTH));
    r = 64'd0;
    if (!e) begin
      for (int i = 0; i < 8; i++) begin
        if (w) mm[s][int'(ad) + i] = dat[8*i +: 8];
        else   r[8*i +: 8] = mm[s][int'(ad) + i];
      end
    end
  endfunction

  // One request from the idle point (just after a clock edge); returns response.
  task automatic do_req(input int s, input logic w, input logic [63:0] ad,
                        input logic [63:0] dat, output logic [63:0] rdata,
                        output logic err);
    int k;
    int exp_lat;
    exp_lat = (s == 0) ? 2 : 0;
    chk("ready_idle", 64'(rdy[s]), 64'd1);
    v[s] = 1'b1; we[s] = w; a[s] = ad; wd[s] = dat;
    @(posedge clk); #1;
    v[s] = 1'b0; we[s] = 1'($urandom); a[s] = {$urandom, $urandom}; wd[s] = {$urandom, $urandom};
    chk("busy_after_accept", 64'(bs[s]), 64'd1);
    chk("ready_after_accept", 64'(rdy[s]), 64'd0);
    k = 0;
    while (!rv[s] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 64'(k), 64'(exp_lat));
    rdata = rd[s];
    err   = er[s];
    @(posedge clk); #1;
    chk("pulse_width", 64'(rv[s]), 64'd0);
    chk("ready_back", 64'(rdy[s]), 64'd1);
  endtask

  task automatic run_req(input int s, input logic w, input logic [63:0] ad, input logic [63:0] dat);
    logic [63:0] er_d, got_d;
    logic        er_e, got_e;
    model(s, w, ad, dat, er_d, er_e);
    do_req(s, w, ad, dat, got_d, got_e);
    chk("rand_rdata", got_d, er_d);
    chk("rand_err", 64'(got_e), 64'(er_e));
  endtask

  initial begin
    logic [63:0] md, gd, ad;
    logic        me, ge;
    int          cnt;
    n_tests = 0;
    n_fail  = 0;
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0; we[s] = 1'b0; a[s] = 64'd0; wd[s] = 64'd0;
    end
    rst_n = 1'b1;

    // Reset asserted mid-cycle takes effect at once.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 64'(rdy[s]), 64'd1);
      chk("rst_resp_valid", 64'(rv[s]), 64'd0);
      chk("rst_rdata", rd[s], 64'd0);
      chk("rst_busy", 64'(bs[s]), 64'd0);
      chk("rst_err", 64'(er[s]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give the model a fully known array.
    for (int i = 0; i < DEPTH / 8; i++) begin
      run_req(0, 1'b1, 64'(i * 8), {$urandom, $urandom});
    end

    tbl[0]  = '{1'b1, 64'h18, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'd0};
    tbl[1]  = '{1'b1, 64'h10, 64'h1122334455667788, 1'b0, 1'b1, 64'd0};
    tbl[2]  = '{1'b0, 64'h10, 64'd0, 1'b0, 1'b1, 64'h1122334455667788};
    tbl[3]  = '{1'b0, 64'h11, 64'd0, 1'b0, 1'b1, 64'hEF11223344556677};
    tbl[4]  = '{1'b0, 64'h3F8, 64'd0, 1'b0, 1'b0, 64'd0};
    tbl[5]  = '{1'b1, 64'h3F9, 64'hDEADBEEFCAFEF00D, 1'b1, 1'b1, 64'd0};
    tbl[6]  = '{1'b0, 64'h3F8, 64'd0, 1'b0, 1'b0, 64'd0};
    tbl[7]  = '{1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 1'b1, 1'b1, 64'd0};
    tbl[8]  = '{1'b1, 64'h3FF, 64'h5555555555555555, 1'b1, 1'b1, 64'd0};
    tbl[9]  = '{1'b1, 64'h3F8, 64'h0F0E0D0C0B0A0908, 1'b0, 1'b1, 64'd0};
    tbl[10] = '{1'b0, 64'h3F8, 64'd0, 1'b0, 1'b1, 64'h0F0E0D0C0B0A0908};
    tbl[11] = '{1'b0, 64'h3FC, 64'd0, 1'b1, 1'b1, 64'd0};

    for (int i = 0; i < 12; i++) begin
      model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, md, me);
      do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, gd, ge);
      chk($sformatf("tbl%0d_err", i), 64'(ge), 64'(tbl[i].exp_err));
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_rdata", i), gd, tbl[i].exp_rdata);
      else                 chk($sformatf("tbl%0d_rdata_model", i), gd, md);
    end

    // Reset during WAIT drops the store and produces no response.
    v[0] = 1'b1; we[0] = 1'b1; a[0] = 64'h20; wd[0] = 64'hAAAAAAAAAAAAAAAA;
    @(posedge clk); #1;
    v[0] = 1'b0;
    chk("wait_busy", 64'(bs[0]), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("midwait_rst_ready", 64'(rdy[0]), 64'd1);
    chk("midwait_rst_busy", 64'(bs[0]), 64'd0);
    chk("midwait_rst_rv", 64'(rv[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (rv[0]) cnt++;
      @(posedge clk); #1;
    end
    chk("no_resp_after_rst", 64'(cnt), 64'd0);
    run_req(0, 1'b0, 64'h20, 64'd0);

    // Zero wait states: back-to-back loads with req_valid held high.
    run_req(1, 1'b1, 64'h40, 64'h8877665544332211);
    run_req(1, 1'b0, 64'h40, 64'd0);
    v[1] = 1'b1; we[1] = 1'b0; a[1] = 64'h40;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("hold_rv", 64'(rv[1]), 64'(k % 2));
      chk("hold_ready", 64'(rdy[1]), 64'((k + 1) % 2));
      if (k % 2 == 1) chk("hold_rdata", rd[1], 64'h8877665544332211);
    end
    v[1] = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      int sel, kind;
      sel  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      kind = $urandom_range(0, 9);
      if (kind <= 6)      ad = 64'($urandom_range(0, DEPTH - 8));
      else if (kind == 7) ad = 64'($urandom_range(DEPTH - 8, DEPTH - 7));
      else if (kind == 8) ad = 64'($urandom_range(DEPTH - 6, DEPTH + 8));
      else                ad = {$urandom, $urandom};
      // Loads on the zero-wait instance only touch bytes it has been given.
      if (sel == 1 && ad <= 64'(DEPTH - 8)) begin
        run_req(1, 1'b1, ad, {$urandom, $urandom});
      end
      run_req(sel, 1'($urandom), ad, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
